// File: rtl/mips_mem_pkg.sv
// Shared encodings and lane-formatting helpers for the MIPS32 memory-access stage.
package mips_mem_pkg;

  localparam logic [1:0] MEM_B = 2'b00;
  localparam logic [1:0] MEM_H = 2'b01;
  localparam logic [1:0] MEM_W = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    DONE = 2'b10
  } state_e;

  function automatic logic [3:0] store_be(input logic [1:0] size, input logic [1:0] lo);
    logic [3:0] be;
    be = 4'b0000;
    case (size)
      MEM_B:   be = 4'b0001 << lo;
      MEM_H:   be = lo[1] ? 4'b1100 : 4'b0011;
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

  function automatic logic [31:0] store_wdata(input logic [1:0] size, input logic [31:0] d);
    logic [31:0] w;
    w = d;
    case (size)
      MEM_B:   w = {4{d[7:0]}};
      MEM_H:   w = {2{d[15:0]}};
      default: w = d;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/load_align.sv
// Selects the addressed byte/half lane of a read word and sign- or zero-extends it.
module load_align
  import mips_mem_pkg::*;
(
  input  logic [31:0] rdata_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [1:0]  size_i,
  input  logic        unsigned_i,
  output logic [31:0] result_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = 8'h00;
    case (addr_lo_i)
      2'd0:    byte_sel = rdata_i[7:0];
      2'd1:    byte_sel = rdata_i[15:8];
      2'd2:    byte_sel = rdata_i[23:16];
      default: byte_sel = rdata_i[31:24];
    endcase
    half_sel = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];

    result_o = rdata_i;
    case (size_i)
      MEM_B:   result_o = {{24{byte_sel[7] & ~unsigned_i}}, byte_sel};
      MEM_H:   result_o = {{16{half_sel[15] & ~unsigned_i}}, half_sel};
      default: result_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// MIPS32 MEM stage: drives the data-memory bus, formats loads, stalls while busy.
// Bus handshake: dmem_req rises with dmem_we/be/wdata stable and holds until the
// cycle dmem_ack is sampled high (or the timeout fires); dmem_ack outside BUSY is ignored.
module mem_stage
  import mips_mem_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] ialu_res,
  input  logic [31:0] istore_data,
  input  logic        imem_read,
  input  logic        imem_write,
  input  logic [1:0]  imem_size,
  input  logic        iload_unsigned,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ack,
  output logic [31:0] oData_mem_res,
  output logic        ostall,
  output logic        omisaligned,
  output logic        obus_err,
  output logic [1:0]  odbg_state
);

  localparam int CW = $clog2(TIMEOUT);

  state_e      state_q;
  logic [CW-1:0] cnt_q;
  logic        we_q;
  logic [3:0]  be_q;
  logic [31:0] wdata_q;
  logic [1:0]  lo_q;
  logic [1:0]  size_q;
  logic        uns_q;
  logic [31:0] res_q;
  logic        err_q;

  logic        mem_op;
  logic        misaligned;
  logic        access;
  logic [31:0] load_res;

  always_comb begin
    misaligned = 1'b0;
    case (imem_size)
      MEM_B:   misaligned = 1'b0;
      MEM_H:   misaligned = ialu_res[0];
      MEM_W:   misaligned = |ialu_res[1:0];
      default: misaligned = 1'b1;
    endcase
  end

  assign mem_op = imem_read | imem_write;
  assign access = mem_op & ~misaligned;

  // Lane info is captured at issue so formatting does not depend on EX/MEM during BUSY.
  load_align u_load_align (
    .rdata_i    (dmem_rdata),
    .addr_lo_i  (lo_q),
    .size_i     (size_q),
    .unsigned_i (uns_q),
    .result_o   (load_res)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      be_q    <= 4'b0000;
      wdata_q <= 32'h0;
      lo_q    <= 2'b00;
      size_q  <= MEM_W;
      uns_q   <= 1'b0;
      res_q   <= 32'h0;
      err_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (access) begin
            state_q <= BUSY;
            cnt_q   <= '0;
            we_q    <= imem_write;
            be_q    <= store_be(imem_size, ialu_res[1:0]);
            wdata_q <= store_wdata(imem_size, istore_data);
            lo_q    <= ialu_res[1:0];
            size_q  <= imem_size;
            uns_q   <= iload_unsigned;
          end
        end
        BUSY: begin
          if (dmem_ack) begin
            state_q <= DONE;
            if (!we_q) res_q <= load_res;
          end else if (cnt_q == CW'(TIMEOUT - 1)) begin
            state_q <= DONE;
            err_q   <= 1'b1;
            if (!we_q) res_q <= 32'h0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        DONE: begin
          state_q <= IDLE;
          err_q   <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign dmem_req      = (state_q == BUSY);
  assign dmem_we       = we_q;
  assign dmem_be       = be_q;
  assign dmem_wdata    = wdata_q;
  assign dmem_addr     = {ialu_res[31:2], 2'b00};
  assign oData_mem_res = res_q;
  assign obus_err      = err_q;
  assign ostall        = ((state_q == IDLE) & access) | (state_q == BUSY);
  assign omisaligned   = (state_q == IDLE) & mem_op & misaligned;
  assign odbg_state    = state_q;

endmodule
